// File: rtl/expmod_uart_ctrl.sv
// Byte-framed request controller between the 8-bit UART pair and the exponent_modulus engine.
// Opcode 0x01 loads and stores a key; opcode 0x02 reuses the stored key.
module expmod_uart_ctrl #(
    parameter int unsigned MSG_WIDTH      = 16,
    parameter int unsigned KEY_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [7:0]           rx_byte_in,
    input  logic                 rx_valid_in,
    output logic [7:0]           tx_byte_out,
    output logic                 tx_trigger_out,
    input  logic                 tx_busy_in,
    output logic                 expmod_ready_out,
    output logic [MSG_WIDTH-1:0] expmod_value_out,
    output logic [KEY_WIDTH-1:0] expmod_exponent_out,
    output logic [KEY_WIDTH-1:0] expmod_modulus_out,
    input  logic [KEY_WIDTH-1:0] expmod_result_in,
    input  logic                 expmod_busy_in,
    input  logic                 expmod_valid_in,
    output logic                 key_loaded_out,
    output logic                 busy_out,
    output logic [7:0]           err_count_out
);

    localparam int unsigned SrW       = 2 * KEY_WIDTH + MSG_WIDTH;
    localparam int unsigned LoadBytes = SrW / 8;
    localparam int unsigned UseBytes  = MSG_WIDTH / 8;
    localparam int unsigned CntW      = $clog2(LoadBytes + 1);
    localparam int unsigned TxBytes   = KEY_WIDTH / 8 + 1;
    localparam int unsigned TxW       = $clog2(TxBytes + 1);
    localparam int unsigned TmoW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OpLoad      = 8'h01;
    localparam logic [7:0] OpUse       = 8'h02;
    localparam logic [7:0] StatOk      = 8'h00;
    localparam logic [7:0] StatBadOp   = 8'hE0;
    localparam logic [7:0] StatNoKey   = 8'hE1;
    localparam logic [7:0] StatZeroMod = 8'hE2;

    typedef enum logic [2:0] {
        StIdle,
        StRxArgs,
        StLaunch,
        StWaitEngine,
        StTxStatus,
        StTxData
    } state_e;

    state_e                state_q;
    logic                  load_op_q;
    logic [CntW-1:0]       rx_left_q;
    logic [TmoW-1:0]       tmo_q;
    logic [SrW-1:0]        sr_q;
    logic [SrW-1:0]        sr_next;
    logic [KEY_WIDTH+7:0]  tx_sr_q;
    logic [TxW-1:0]        tx_left_q;
    logic                  trig_prev_q;
    logic [KEY_WIDTH-1:0]  key_mod_q;
    logic [KEY_WIDTH-1:0]  key_exp_q;
    logic                  key_loaded_q;
    logic [7:0]            err_q;
    logic                  ready_q;
    logic [MSG_WIDTH-1:0]  value_q;
    logic [KEY_WIDTH-1:0]  exp_q;
    logic [KEY_WIDTH-1:0]  mod_q;
    logic                  tx_fire;
    logic                  unused_engine_busy;

    // Launch timing is fixed relative to the last operand byte, so engine busy is not consulted.
    assign unused_engine_busy = expmod_busy_in;

    always_comb begin
        sr_next = {sr_q[SrW-9:0], rx_byte_in};
    end

    assign tx_fire = ((state_q == StTxStatus) || (state_q == StTxData)) &&
                     (tx_left_q != '0) && !tx_busy_in && !trig_prev_q;

    assign tx_byte_out         = tx_sr_q[KEY_WIDTH +: 8];
    assign tx_trigger_out      = tx_fire;
    assign expmod_ready_out    = ready_q;
    assign expmod_value_out    = value_q;
    assign expmod_exponent_out = exp_q;
    assign expmod_modulus_out  = mod_q;
    assign key_loaded_out      = key_loaded_q;
    assign busy_out            = (state_q != StIdle);
    assign err_count_out       = err_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            load_op_q    <= 1'b0;
            rx_left_q    <= '0;
            tmo_q        <= '0;
            sr_q         <= '0;
            tx_sr_q      <= '0;
            tx_left_q    <= '0;
            trig_prev_q  <= 1'b0;
            key_mod_q    <= '0;
            key_exp_q    <= '0;
            key_loaded_q <= 1'b0;
            err_q        <= '0;
            ready_q      <= 1'b0;
            value_q      <= '0;
            exp_q        <= '0;
            mod_q        <= '0;
        end else begin
            ready_q     <= 1'b0;
            trig_prev_q <= tx_fire;
            case (state_q)
                StIdle: begin
                    if (rx_valid_in) begin
                        if ((rx_byte_in == OpLoad) || (rx_byte_in == OpUse)) begin
                            load_op_q <= (rx_byte_in == OpLoad);
                            rx_left_q <= (rx_byte_in == OpLoad) ? CntW'(LoadBytes)
                                                                : CntW'(UseBytes);
                            tmo_q     <= '0;
                            sr_q      <= '0;
                            state_q   <= StRxArgs;
                        end else begin
                            tx_sr_q   <= {StatBadOp, {KEY_WIDTH{1'b0}}};
                            tx_left_q <= TxW'(1);
                            err_q     <= sat_inc(err_q);
                            state_q   <= StTxStatus;
                        end
                    end
                end
                StRxArgs: begin
                    // A byte landing on the expiry cycle is swallowed by the timeout.
                    if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= sat_inc(err_q);
                        state_q <= StIdle;
                    end else if (rx_valid_in) begin
                        sr_q      <= sr_next;
                        tmo_q     <= '0;
                        rx_left_q <= rx_left_q - CntW'(1);
                        if (rx_left_q == CntW'(1)) begin
                            if (load_op_q && (sr_next[SrW-1 -: KEY_WIDTH] == '0)) begin
                                tx_sr_q   <= {StatZeroMod, {KEY_WIDTH{1'b0}}};
                                tx_left_q <= TxW'(1);
                                err_q     <= sat_inc(err_q);
                                state_q   <= StTxStatus;
                            end else if (!load_op_q && !key_loaded_q) begin
                                tx_sr_q   <= {StatNoKey, {KEY_WIDTH{1'b0}}};
                                tx_left_q <= TxW'(1);
                                err_q     <= sat_inc(err_q);
                                state_q   <= StTxStatus;
                            end else begin
                                value_q <= sr_next[MSG_WIDTH-1:0];
                                exp_q   <= load_op_q ? sr_next[MSG_WIDTH +: KEY_WIDTH] : key_exp_q;
                                mod_q   <= load_op_q ? sr_next[SrW-1 -: KEY_WIDTH] : key_mod_q;
                                ready_q <= 1'b1;
                                state_q <= StLaunch;
                            end
                        end
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StLaunch: begin
                    if (load_op_q) begin
                        key_mod_q    <= mod_q;
                        key_exp_q    <= exp_q;
                        key_loaded_q <= 1'b1;
                    end
                    if (rx_valid_in) err_q <= sat_inc(err_q);
                    state_q <= StWaitEngine;
                end
                StWaitEngine: begin
                    if (rx_valid_in) err_q <= sat_inc(err_q);
                    if (expmod_valid_in) begin
                        tx_sr_q   <= {StatOk, expmod_result_in};
                        tx_left_q <= TxW'(TxBytes);
                        state_q   <= StTxStatus;
                    end
                end
                StTxStatus, StTxData: begin
                    if (rx_valid_in) err_q <= sat_inc(err_q);
                    if (tx_fire) begin
                        tx_sr_q   <= {tx_sr_q[KEY_WIDTH-1:0], 8'h00};
                        tx_left_q <= tx_left_q - TxW'(1);
                        state_q   <= StTxData;
                    end else if ((tx_left_q == '0) && !trig_prev_q && !tx_busy_in) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_expmod_uart_ctrl.sv
// Scoreboard bench for expmod_uart_ctrl: stimulus pushes expected launches and tx bytes,
// monitors pop and compare whenever the DUT launches the engine or triggers a transmit.
module tb_expmod_uart_ctrl;

    localparam int unsigned MW = 16;
    localparam int unsigned KW = 32;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [7:0]    rx_byte_in;
    logic          rx_valid_in;
    logic [7:0]    tx_byte_out;
    logic          tx_trigger_out;
    logic          tx_busy_in;
    logic          expmod_ready_out;
    logic [MW-1:0] expmod_value_out;
    logic [KW-1:0] expmod_exponent_out;
    logic [KW-1:0] expmod_modulus_out;
    logic [KW-1:0] expmod_result_in;
    logic          expmod_busy_in;
    logic          expmod_valid_in;
    logic          key_loaded_out;
    logic          busy_out;
    logic [7:0]    err_count_out;

    logic stub_busy = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy_in = stub_busy | force_busy;

    int checks = 0;
    int errors = 0;
    int eng_delay = 5;
    logic [KW-1:0] eng_result = '0;

    logic [7:0]         tx_q[$];
    logic [MW+2*KW-1:0] op_q[$];
    logic [7:0]         mon_b;
    logic [MW+2*KW-1:0] mon_op;
    logic               prev_trig = 1'b0;
    logic               prev_ready = 1'b0;

    always #5 clk_in = ~clk_in;

    expmod_uart_ctrl #(
        .MSG_WIDTH     (MW),
        .KEY_WIDTH     (KW),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rx_byte_in         (rx_byte_in),
        .rx_valid_in        (rx_valid_in),
        .tx_byte_out        (tx_byte_out),
        .tx_trigger_out     (tx_trigger_out),
        .tx_busy_in         (tx_busy_in),
        .expmod_ready_out   (expmod_ready_out),
        .expmod_value_out   (expmod_value_out),
        .expmod_exponent_out(expmod_exponent_out),
        .expmod_modulus_out (expmod_modulus_out),
        .expmod_result_in   (expmod_result_in),
        .expmod_busy_in     (expmod_busy_in),
        .expmod_valid_in    (expmod_valid_in),
        .key_loaded_out     (key_loaded_out),
        .busy_out           (busy_out),
        .err_count_out      (err_count_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors sample on the falling edge, away from the DUT's active edge.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (tx_trigger_out) begin
                check("trigger_while_busy", {31'd0, tx_busy_in}, 32'd0);
                check("trigger_spacing", {31'd0, prev_trig}, 32'd0);
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: got byte 0x%0h expected none", tx_byte_out);
                end else begin
                    mon_b = tx_q.pop_front();
                    if (tx_byte_out !== mon_b) begin
                        errors++;
                        $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_byte_out, mon_b);
                    end
                end
            end
            if (expmod_ready_out) begin
                check("ready_width", {31'd0, prev_ready}, 32'd0);
                checks++;
                if (op_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_launch: got value 0x%0h expected none",
                             expmod_value_out);
                end else begin
                    mon_op = op_q.pop_front();
                    if ({expmod_value_out, expmod_exponent_out, expmod_modulus_out} !== mon_op) begin
                        errors++;
                        $display("FAIL operands: got 0x%0h/0x%0h/0x%0h expected 0x%0h",
                                 expmod_value_out, expmod_exponent_out, expmod_modulus_out,
                                 mon_op);
                    end
                end
            end
        end
        prev_trig  = tx_trigger_out;
        prev_ready = expmod_ready_out;
    end

    // Engine stub: answers each launch after eng_delay cycles.
    initial begin
        expmod_valid_in  = 1'b0;
        expmod_result_in = '0;
        expmod_busy_in   = 1'b0;
        forever begin
            @(negedge clk_in);
            if (expmod_ready_out) begin
                expmod_busy_in = 1'b1;
                repeat (eng_delay) @(posedge clk_in);
                #1;
                expmod_result_in = eng_result;
                expmod_valid_in  = 1'b1;
                expmod_busy_in   = 1'b0;
                @(posedge clk_in);
                #1 expmod_valid_in = 1'b0;
            end
        end
    end

    // Transmitter stub: busy for 3 cycles after each accepted trigger.
    initial begin
        forever begin
            @(negedge clk_in);
            if (tx_trigger_out) begin
                @(posedge clk_in);
                #1 stub_busy = 1'b1;
                repeat (3) @(posedge clk_in);
                #1 stub_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_in);
        #1;
        rx_byte_in  = b;
        rx_valid_in = 1'b1;
        @(posedge clk_in);
        #1 rx_valid_in = 1'b0;
    endtask

    task automatic send_load(input logic [KW-1:0] m, input logic [KW-1:0] e, input logic [MW-1:0] v);
        send_byte(8'h01);
        for (int i = KW / 8 - 1; i >= 0; i--) send_byte(m[8*i +: 8]);
        for (int i = KW / 8 - 1; i >= 0; i--) send_byte(e[8*i +: 8]);
        for (int i = MW / 8 - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
    endtask

    task automatic send_use(input logic [MW-1:0] v);
        send_byte(8'h02);
        for (int i = MW / 8 - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
    endtask

    task automatic push_ok(input logic [KW-1:0] r);
        tx_q.push_back(8'h00);
        for (int i = KW / 8 - 1; i >= 0; i--) tx_q.push_back(r[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_in);
            if (!busy_out) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, {31'd0, seen}, 32'd1);
        check({name, "_tx_drained"}, tx_q.size(), 32'd0);
        check({name, "_launch_drained"}, op_q.size(), 32'd0);
    endtask

    initial begin
        rst_in      = 1'b0;
        rx_byte_in  = 8'h00;
        rx_valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_key_loaded", {31'd0, key_loaded_out}, 32'd0);
        check("rst_err_count", {24'd0, err_count_out}, 32'd0);
        check("rst_trigger", {31'd0, tx_trigger_out}, 32'd0);
        check("rst_ready", {31'd0, expmod_ready_out}, 32'd0);
        check("rst_modulus", expmod_modulus_out, 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;

        // Use-key with nothing stored.
        tx_q.push_back(8'hE1);
        send_use(16'h0007);
        @(negedge clk_in);
        check("nokey_trigger_timing", {31'd0, tx_trigger_out}, 32'd1);
        wait_idle("nokey");
        check("nokey_err", {24'd0, err_count_out}, 32'd1);
        check("nokey_key_loaded", {31'd0, key_loaded_out}, 32'd0);

        // Full load frame.
        eng_result = 32'h0000_0123;
        op_q.push_back({16'h0005, 32'h0000_0048, 32'h0000_0431});
        push_ok(32'h0000_0123);
        send_load(32'h0000_0431, 32'h0000_0048, 16'h0005);
        @(negedge clk_in);
        check("load_ready_timing", {31'd0, expmod_ready_out}, 32'd1);
        wait_idle("load");
        check("load_key_loaded", {31'd0, key_loaded_out}, 32'd1);
        check("load_err", {24'd0, err_count_out}, 32'd1);

        // Stored-key frame.
        eng_result = 32'h0000_0456;
        op_q.push_back({16'h0007, 32'h0000_0048, 32'h0000_0431});
        push_ok(32'h0000_0456);
        send_use(16'h0007);
        wait_idle("use");

        // Bad opcode.
        tx_q.push_back(8'hE0);
        send_byte(8'h7F);
        @(negedge clk_in);
        check("badop_trigger_timing", {31'd0, tx_trigger_out}, 32'd1);
        wait_idle("badop");
        check("badop_err", {24'd0, err_count_out}, 32'd2);

        // Zero modulus must not disturb the stored key.
        tx_q.push_back(8'hE2);
        send_load(32'h0, 32'h0000_0011, 16'h0022);
        wait_idle("zeromod");
        check("zeromod_err", {24'd0, err_count_out}, 32'd3);
        check("zeromod_key_loaded", {31'd0, key_loaded_out}, 32'd1);
        eng_result = 32'h0000_0002;
        op_q.push_back({16'h0001, 32'h0000_0048, 32'h0000_0431});
        push_ok(32'h0000_0002);
        send_use(16'h0001);
        wait_idle("key_kept");
        check("key_kept_err", {24'd0, err_count_out}, 32'd3);

        // Timeout after partial frame.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        repeat (99) @(posedge clk_in);
        #1 check("tmo_before_expiry", {31'd0, busy_out}, 32'd1);
        @(posedge clk_in);
        #1 check("tmo_expired", {31'd0, busy_out}, 32'd0);
        check("tmo_err", {24'd0, err_count_out}, 32'd4);

        // A byte on the expiry cycle is the timeout, not a drop or an opcode.
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (99) @(posedge clk_in);
        #1;
        rx_byte_in  = 8'h7F;
        rx_valid_in = 1'b1;
        @(posedge clk_in);
        #1 rx_valid_in = 1'b0;
        check("tmo_edge_idle", {31'd0, busy_out}, 32'd0);
        check("tmo_edge_err", {24'd0, err_count_out}, 32'd5);

        eng_result = 32'h0000_ABCD;
        op_q.push_back({16'h0003, 32'h0000_0048, 32'h0000_0431});
        push_ok(32'h0000_ABCD);
        send_use(16'h0003);
        wait_idle("after_tmo");
        check("after_tmo_err", {24'd0, err_count_out}, 32'd5);

        // Drops during the engine wait, then a held transmitter.
        eng_delay  = 340;
        eng_result = 32'hCAFE_F00D;
        op_q.push_back({16'h0009, 32'h0000_0048, 32'h0000_0431});
        push_ok(32'hCAFE_F00D);
        send_use(16'h0009);
        @(negedge clk_in);
        check("sat_ready_timing", {31'd0, expmod_ready_out}, 32'd1);
        repeat (2) @(posedge clk_in);
        #1;
        rx_byte_in  = 8'h55;
        rx_valid_in = 1'b1;
        repeat (300) @(posedge clk_in);
        #1;
        rx_valid_in = 1'b0;
        check("sat_err_during_wait", {24'd0, err_count_out}, 32'd255);
        force_busy = 1'b1;
        repeat (50) @(posedge clk_in);
        #1;
        check("reply_held_while_busy", tx_q.size(), 32'd5);
        force_busy = 1'b0;
        wait_idle("sat");
        check("sat_err_final", {24'd0, err_count_out}, 32'd255);
        eng_delay = 5;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
